// File: rtl/sweep_avg_ctrl.sv
// Bolometer sweep sequencer: per-point DAC write, settle, averaged ADC capture, then RS232 dump of the result RAM.
// Optional macro SWEEP_ABORT_EN adds abort_i, which ends the sweep once the pending peripheral handshake completes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start_i
// DAC      | issue DAC write for the current point
// DAC_W    | wait for eodac_i
// SETTLE   | settle down-counter running
// ADC      | issue ADC conversion
// ADC_W    | wait for eoadc_i, accumulate sample
// STORE    | write the point average into the result RAM
// RD       | present RAM read address
// RD_W     | RAM read latency
// RD_L     | latch RAM data into the hold register
// TXM      | send MSB nibble byte
// TXM_W    | wait for eotx_i
// TXL      | send LSB byte
// TXL_W    | wait for eotx_i, advance or finish
// DONE     | pulse eos_o, drop busy_o
module sweep_avg_ctrl #(
    parameter int NPTS     = 400,
    parameter int LOG2_AVG = 2,
    parameter int SETTLE_W = 20,
    parameter int SETTLE   = 500000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        eodac_i,
    input  logic        eoadc_i,
    input  logic        eotx_i,
`ifdef SWEEP_ABORT_EN
    input  logic        abort_i,
`endif
    input  logic [11:0] adc_d_i,
    input  logic [11:0] ram_d_i,
    output logic        stdac_o,
    output logic [8:0]  code_o,
    output logic        stadc_o,
    output logic        stx_o,
    output logic [7:0]  tx_d_o,
    output logic        we_o,
    output logic [8:0]  addr_o,
    output logic [11:0] wdata_o,
    output logic        busy_o,
    output logic        eos_o
);

    localparam int                ACC_W     = 12 + LOG2_AVG;
    localparam logic [8:0]        LAST      = 9'(NPTS - 1);
    localparam logic [LOG2_AVG:0] NAVG      = (LOG2_AVG + 1)'(1 << LOG2_AVG);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

    typedef enum logic [3:0] {
        S_IDLE, S_DAC, S_DAC_W, S_SETTLE, S_ADC, S_ADC_W, S_STORE,
        S_RD, S_RD_W, S_RD_L, S_TXM, S_TXM_W, S_TXL, S_TXL_W, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [8:0]          idx, idx_n;
    logic [LOG2_AVG:0]   scnt, scnt_n;
    logic [SETTLE_W-1:0] settle_cnt, settle_n;
    logic [ACC_W-1:0]    acc, acc_n;
    logic [11:0]         hold, hold_n;
    logic                stdac_n, stadc_n, stx_n, we_n, eos_n, busy_n;
    logic [8:0]          code_n, addr_n;
    logic [7:0]          tx_n;
    logic [11:0]         wdata_n;
    logic                abort_now;

`ifdef SWEEP_ABORT_EN
    logic abort_q;

    // Abort is acted on at the next decision point, so in-flight SPI/UART transfers finish cleanly.
    assign abort_now = abort_q | abort_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            abort_q <= 1'b0;
        else if (state == S_IDLE)
            abort_q <= 1'b0;
        else if (abort_i)
            abort_q <= 1'b1;
    end
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            idx        <= '0;
            scnt       <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            hold       <= '0;
            stdac_o    <= 1'b0;
            code_o     <= '0;
            stadc_o    <= 1'b0;
            stx_o      <= 1'b0;
            tx_d_o     <= '0;
            we_o       <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            busy_o     <= 1'b0;
            eos_o      <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            scnt       <= scnt_n;
            settle_cnt <= settle_n;
            acc        <= acc_n;
            hold       <= hold_n;
            stdac_o    <= stdac_n;
            code_o     <= code_n;
            stadc_o    <= stadc_n;
            stx_o      <= stx_n;
            tx_d_o     <= tx_n;
            we_o       <= we_n;
            addr_o     <= addr_n;
            wdata_o    <= wdata_n;
            busy_o     <= busy_n;
            eos_o      <= eos_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        scnt_n   = scnt;
        settle_n = settle_cnt;
        acc_n    = acc;
        hold_n   = hold;
        stdac_n  = 1'b0;
        stadc_n  = 1'b0;
        stx_n    = 1'b0;
        we_n     = 1'b0;
        eos_n    = 1'b0;
        code_n   = code_o;
        tx_n     = tx_d_o;
        addr_n   = addr_o;
        wdata_n  = wdata_o;
        busy_n   = busy_o;

        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    idx_n   = '0;
                    code_n  = '0;
                    busy_n  = 1'b1;
                    state_n = S_DAC;
                end
            end
            S_DAC: begin
                if (abort_now) begin
                    state_n = S_DONE;
                end else begin
                    code_n  = idx;
                    stdac_n = 1'b1;
                    state_n = S_DAC_W;
                end
            end
            S_DAC_W: begin
                if (eodac_i) begin
                    settle_n = SETTLE_LD;
                    state_n  = abort_now ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort_now) begin
                    state_n = S_DONE;
                end else if (settle_cnt == '0) begin
                    acc_n   = '0;
                    scnt_n  = '0;
                    state_n = S_ADC;
                end else begin
                    settle_n = settle_cnt - 1'b1;
                end
            end
            S_ADC: begin
                if (abort_now) begin
                    state_n = S_DONE;
                end else begin
                    stadc_n = 1'b1;
                    state_n = S_ADC_W;
                end
            end
            S_ADC_W: begin
                if (eoadc_i) begin
                    acc_n  = acc + ACC_W'(adc_d_i);
                    scnt_n = scnt + 1'b1;
                    if (abort_now)
                        state_n = S_DONE;
                    else if (scnt + 1'b1 == NAVG)
                        state_n = S_STORE;
                    else
                        state_n = S_ADC;
                end
            end
            S_STORE: begin
                if (abort_now) begin
                    state_n = S_DONE;
                end else begin
                    addr_n  = idx;
                    wdata_n = 12'(acc >> LOG2_AVG);
                    we_n    = 1'b1;
                    if (idx == LAST) begin
                        idx_n   = '0;
                        state_n = S_RD;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = S_DAC;
                    end
                end
            end
            S_RD: begin
                if (abort_now) begin
                    state_n = S_DONE;
                end else begin
                    addr_n  = idx;
                    state_n = S_RD_W;
                end
            end
            S_RD_W: state_n = abort_now ? S_DONE : S_RD_L;
            S_RD_L: begin
                hold_n  = ram_d_i;
                state_n = abort_now ? S_DONE : S_TXM;
            end
            S_TXM: begin
                if (abort_now) begin
                    state_n = S_DONE;
                end else begin
                    tx_n    = {4'b0000, hold[11:8]};
                    stx_n   = 1'b1;
                    state_n = S_TXM_W;
                end
            end
            S_TXM_W: if (eotx_i) state_n = abort_now ? S_DONE : S_TXL;
            S_TXL: begin
                if (abort_now) begin
                    state_n = S_DONE;
                end else begin
                    tx_n    = hold[7:0];
                    stx_n   = 1'b1;
                    state_n = S_TXL_W;
                end
            end
            S_TXL_W: begin
                if (eotx_i) begin
                    if (abort_now || idx == LAST) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = S_RD;
                    end
                end
            end
            S_DONE: begin
                eos_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sweep_avg_ctrl.sv
// Directed bench for sweep_avg_ctrl: table of ADC sample sets with expected averages and TX bytes,
// plus hand sequences for ignored starts, mid-sweep reset and (with SWEEP_ABORT_EN) abort.
module tb_sweep_avg_ctrl;

    localparam int NPTS     = 2;
    localparam int LOG2_AVG = 2;
    localparam int SETTLE_W = 20;
    localparam int SETTLE   = 10;
    localparam int NAVG     = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        eodac_i = 1'b0;
    logic        eoadc_i = 1'b0;
    logic        eotx_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [11:0] adc_d_i = '0;
    logic [11:0] ram_d_i = '0;
    logic        stdac_o, stadc_o, stx_o, we_o, busy_o, eos_o;
    logic [8:0]  code_o, addr_o;
    logic [7:0]  tx_d_o;
    logic [11:0] wdata_o;

    always #5 clk_i = ~clk_i;

    sweep_avg_ctrl #(
        .NPTS(NPTS), .LOG2_AVG(LOG2_AVG), .SETTLE_W(SETTLE_W), .SETTLE(SETTLE)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .eodac_i(eodac_i), .eoadc_i(eoadc_i), .eotx_i(eotx_i),
`ifdef SWEEP_ABORT_EN
        .abort_i(abort_i),
`endif
        .adc_d_i(adc_d_i), .ram_d_i(ram_d_i),
        .stdac_o(stdac_o), .code_o(code_o), .stadc_o(stadc_o), .stx_o(stx_o),
        .tx_d_o(tx_d_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .busy_o(busy_o), .eos_o(eos_o)
    );

    typedef struct {
        logic [0:7][11:0] samp;
        logic [11:0]      w0;
        logic [11:0]      w1;
        logic [0:3][7:0]  tx;
    } vec_t;

    vec_t vecs[4];
    logic [0:7][11:0] cur_samp = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [63:0] outs();
        return {20'd0, stdac_o, code_o, stadc_o, stx_o, tx_d_o, we_o, addr_o, wdata_o, busy_o, eos_o};
    endfunction

    // Synchronous-read result RAM, one-cycle latency
    logic [11:0] mem [512];
    always @(posedge clk_i) begin
        if (we_o) mem[addr_o] <= wdata_o;
        ram_d_i <= mem[addr_o];
    end

    // Peripheral responders: fixed latency from start pulse to done pulse
    logic rnd_mode = 1'b0;
    int dac_cnt = 0, adc_cnt = 0, tx_cnt = 0, k = 0;
    always @(negedge clk_i) begin
        eodac_i = 1'b0;
        eoadc_i = 1'b0;
        eotx_i  = 1'b0;
        if (rnd_mode) begin
            eodac_i = 1'($urandom);
            eoadc_i = 1'($urandom);
            eotx_i  = 1'($urandom);
            adc_d_i = 12'($urandom);
        end else if (!rst_i) begin
            dac_cnt = 0;
            adc_cnt = 0;
            tx_cnt  = 0;
        end else begin
            if (dac_cnt != 0) begin
                dac_cnt--;
                if (dac_cnt == 0) eodac_i = 1'b1;
            end
            if (stdac_o) begin
                dac_cnt = 3;
                k = 0;
            end
            if (adc_cnt != 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    eoadc_i = 1'b1;
                    adc_d_i = cur_samp[(int'(code_o) * NAVG + k) & 7];
                    k++;
                end
            end
            if (stadc_o) adc_cnt = 3;
            if (tx_cnt != 0) begin
                tx_cnt--;
                if (tx_cnt == 0) eotx_i = 1'b1;
            end
            if (stx_o) tx_cnt = 4;
        end
    end

    // Event logs
    int cyc = 0;
    logic [8:0]  we_addr[$];
    logic [11:0] we_data[$];
    logic [7:0]  tx_log[$];
    logic [8:0]  dac_codes[$];
    logic [7:0]  tx_last = '0;
    int n_stadc, n_eotx, n_eos, tx_unstable, eotx_at_eos, eos_cyc, eoadc_cyc, eodac_cyc, min_gap;
    bit gap_pend;

    always @(posedge clk_i) begin
        #1;
        cyc++;
        if (we_o) begin
            we_addr.push_back(addr_o);
            we_data.push_back(wdata_o);
        end
        if (stx_o) begin
            tx_log.push_back(tx_d_o);
            tx_last = tx_d_o;
        end
        if (eotx_i) begin
            n_eotx++;
            if (tx_d_o !== tx_last) tx_unstable++;
        end
        if (stadc_o) begin
            n_stadc++;
            if (gap_pend) begin
                gap_pend = 1'b0;
                if (cyc - eodac_cyc < min_gap) min_gap = cyc - eodac_cyc;
            end
        end
        if (eodac_i) begin
            eodac_cyc = cyc;
            gap_pend  = 1'b1;
        end
        if (stdac_o) dac_codes.push_back(code_o);
        if (eoadc_i) eoadc_cyc = cyc;
        if (eos_o) begin
            n_eos++;
            eos_cyc     = cyc;
            eotx_at_eos = n_eotx;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #3;
    endtask

    task automatic clear_logs();
        we_addr.delete();
        we_data.delete();
        tx_log.delete();
        dac_codes.delete();
        n_stadc = 0; n_eotx = 0; n_eos = 0; tx_unstable = 0;
        eotx_at_eos = 0; eos_cyc = 0; eoadc_cyc = 0; eodac_cyc = 0;
        min_gap = 1000000;
        gap_pend = 1'b0;
    endtask

    task automatic run_sweep(input bit inject);
        bit i1 = 1'b0, i2 = 1'b0;
        int n = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (n_eos == 0 && n < 3000) begin
            start_i = 1'b0;
            if (inject && !i1 && stadc_o) begin
                start_i = 1'b1;
                i1 = 1'b1;
            end
            if (inject && !i2 && stx_o && tx_log.size() == 2) begin
                start_i = 1'b1;
                i2 = 1'b1;
            end
            tick();
            n++;
        end
        start_i = 1'b0;
        repeat (20) tick();
    endtask

    task automatic check_sweep(input vec_t v);
        chk("we_count", we_addr.size(), 2);
        chk("we_addr0", we_addr[0], 0);
        chk("we_data0", we_data[0], v.w0);
        chk("we_addr1", we_addr[1], 1);
        chk("we_data1", we_data[1], v.w1);
        chk("dac_code0", dac_codes[0], 0);
        chk("dac_code1", dac_codes[1], 1);
        chk("stadc_count", n_stadc, NAVG * NPTS);
        chk("tx_count", tx_log.size(), 2 * NPTS);
        for (int b = 0; b < 4; b++) chk($sformatf("tx_byte%0d", b), tx_log[b], v.tx[b]);
        chk("tx_stable", tx_unstable, 0);
        chk("eos_count", n_eos, 1);
        chk("eos_after_4th_eotx", eotx_at_eos, 4);
        chk_range("settle_gap", min_gap, SETTLE, 1000);
        chk("busy_after", busy_o, 0);
    endtask

    initial begin
        vecs[0].samp = {12'd100, 12'd101, 12'd102, 12'd103, 12'd4000, 12'd4001, 12'd4002, 12'd4003};
        vecs[0].w0 = 12'd101;  vecs[0].w1 = 12'd4001;
        vecs[0].tx = {8'h00, 8'h65, 8'h0F, 8'hA1};
        vecs[1].samp = {12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'h123, 12'h123, 12'h123, 12'h123};
        vecs[1].w0 = 12'hABC;  vecs[1].w1 = 12'h123;
        vecs[1].tx = {8'h0A, 8'hBC, 8'h01, 8'h23};
        vecs[2].samp = {12'd0, 12'd0, 12'd0, 12'd3, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
        vecs[2].w0 = 12'd0;    vecs[2].w1 = 12'd4095;
        vecs[2].tx = {8'h00, 8'h00, 8'h0F, 8'hFF};
        vecs[3].samp = {12'd7, 12'd6, 12'd5, 12'd4, 12'd1, 12'd2, 12'd3, 12'd4};
        vecs[3].w0 = 12'd5;    vecs[3].w1 = 12'd2;
        vecs[3].tx = {8'h00, 8'h05, 8'h00, 8'h02};
        clear_logs();

        // Reset held with random inputs
        rst_i = 1'b0;
        rnd_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start_i = 1'($urandom);
            abort_i = 1'($urandom);
            tick();
            chk("reset_outs", outs(), 0);
        end
        rnd_mode = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_outs", outs(), 0);
        end

        // Table of sweeps
        for (int v = 0; v < 4; v++) begin
            cur_samp = vecs[v].samp;
            clear_logs();
            run_sweep(1'b0);
            check_sweep(vecs[v]);
        end

        // Stray starts in ADC_W and TXL_W
        cur_samp = vecs[1].samp;
        clear_logs();
        run_sweep(1'b1);
        check_sweep(vecs[1]);

        // Reset while settling on point 1, then restart
        cur_samp = vecs[0].samp;
        clear_logs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int n = 0; n < 500 && !(dac_codes.size() == 2 && gap_pend); n++) tick();
        repeat (4) tick();
        chk("pre_reset_code", code_o, 1);
        chk("pre_reset_busy", busy_o, 1);
        rst_i = 1'b0;
        #1;
        chk("mid_reset_outs", outs(), 0);
        tick();
        rst_i = 1'b1;
        tick();
        clear_logs();
        run_sweep(1'b0);
        check_sweep(vecs[0]);

`ifdef SWEEP_ABORT_EN
        // Abort while waiting for a conversion on point 1
        cur_samp = vecs[0].samp;
        clear_logs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int n = 0; n < 500 && !(code_o == 9'd1 && stadc_o); n++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        for (int n = 0; n < 500 && n_eos == 0; n++) tick();
        repeat (10) tick();
        chk("abort_we_count", we_addr.size(), 1);
        chk("abort_tx_count", tx_log.size(), 0);
        chk("abort_eos_count", n_eos, 1);
        chk_range("abort_eos_delay", eos_cyc - eoadc_cyc, 1, 2);
        chk("abort_busy", busy_o, 0);
        clear_logs();
        run_sweep(1'b0);
        check_sweep(vecs[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sweep_avg_ctrl.md
Name: sweep_avg_ctrl

Overview:
Top-level sequencer for the bolometer sweep datapath, replacing the single-pass FSM.
- Acquisition phase: steps the DAC code (ROM address) from 0 to NPTS-1. For each point it writes the DAC, waits a programmable settle time, takes 2^LOG2_AVG ADC conversions, averages them and stores the result in the 12-bit result RAM.
- Transmit phase: streams the whole RAM over the RS232 transmitter as MSB/LSB byte pairs.
- Sits between the start tick and the SPI DAC writer, SPI ADC reader, RS232 TX and result RAM.

Parameters:
NPTS, 400, number of sweep points; RAM depth used; range 1..512
LOG2_AVG, 2, log2 of ADC conversions averaged per point; range 0..4
SETTLE_W, 20, settle counter width
SETTLE, 500000, settle wait in clk cycles after eodac_i (5 ms at 100 MHz); range 0..2^SETTLE_W-1

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle start pulse from the tick module
eodac_i  in  1  DAC SPI write done, one-cycle pulse
eoadc_i  in  1  ADC conversion done, one-cycle pulse; adc_d_i valid in that cycle
eotx_i  in  1  RS232 byte done, one-cycle pulse
adc_d_i  in  12  ADC sample
ram_d_i  in  12  RAM read data; synchronous read, 1-cycle latency
stdac_o  out  1  DAC write start pulse
code_o  out  9  DAC ROM address (sweep point index)
stadc_o  out  1  ADC conversion start pulse
stx_o  out  1  TX byte start pulse
tx_d_o  out  8  TX byte
we_o  out  1  RAM write enable, one cycle
addr_o  out  9  RAM address
wdata_o  out  12  RAM write data (point average)
busy_o  out  1  high from accepted start until eos_o
eos_o  out  1  end-of-sweep pulse, one cycle

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all outputs 0; point index, sample counter, settle counter and accumulator cleared.
- All st*_o, we_o and eos_o are registered single-cycle pulses.
- Each st*_o is issued only from a state that then waits for the matching eo*_i. An eo*_i arriving in any other state is ignored.
- IDLE: on start_i, clear point index and go to DAC. start_i is ignored in every non-IDLE state.
- DAC: code_o = point index; pulse stdac_o; go to DAC_W.
- DAC_W: wait for eodac_i, load settle counter, go to SETTLE.
- SETTLE: count SETTLE cycles, then clear accumulator and sample counter, go to ADC. SETTLE=0 passes through in one cycle.
- ADC: pulse stadc_o; go to ADC_W.
- ADC_W: on eoadc_i, acc += adc_d_i and sample counter += 1.
  - If sample counter reaches 2^LOG2_AVG, go to STORE; otherwise return to ADC.
  - Accumulator width is 12+LOG2_AVG and cannot overflow.
- STORE: addr_o = point index; wdata_o = acc >> LOG2_AVG (truncating); pulse we_o.
  - If point index = NPTS-1, clear the index and go to RD. Otherwise increment the index and go to DAC.
- RD: addr_o = index; wait one cycle for RAM latency; latch ram_d_i into a 12-bit hold register; go to TXM.
- TXM: tx_d_o = {4'b0000, hold[11:8]}; pulse stx_o; wait for eotx_i.
- TXL: tx_d_o = hold[7:0]; pulse stx_o; wait for eotx_i.
  - If index = NPTS-1, go to DONE. Otherwise increment the index and go to RD.
- tx_d_o is held stable from the stx_o pulse until eotx_i.
- DONE: pulse eos_o, clear busy_o, go to IDLE.
- Reset asserted mid-sweep aborts immediately; no partial state survives.
- code_o holds its last value between points and returns to 0 only on reset or on a new start.

Optional Feature:
Macro SWEEP_ABORT_EN.
- Defined: adds input abort_i (1 bit).
  - abort_i sampled high in any busy state sets a sticky abort flag.
  - The current peripheral handshake (pending eodac_i, eoadc_i or eotx_i) still completes so SPI/UART transactions are never truncated.
  - Then the FSM goes directly to DONE and pulses eos_o; no further stdac_o, stadc_o, stx_o or we_o is issued.
  - The flag clears in IDLE.
- Not defined: no abort_i port; a sweep always runs to completion.

Test Plan:
1. Reset: hold rst_i low, drive random inputs -> all outputs 0, busy_o 0; release -> outputs stay 0 until start_i.
2. NPTS=2, LOG2_AVG=2, SETTLE=10; ADC model returns 100,101,102,103 then 4000,4001,4002,4003 -> we_o writes addr 0 = 101 and addr 1 = 4001; the first stadc_o of each point comes no earlier than 10 cycles after eodac_i.
3. Transmit check, RAM preloaded 0xABC at addr 0 and 0x123 at addr 1 -> TX bytes in order 0x0A, 0xBC, 0x01, 0x23; eos_o pulses exactly once, after the fourth eotx_i.
4. start_i pulsed during ADC_W and during TXL -> ignored; exactly 2^LOG2_AVG*NPTS stadc_o pulses and 2*NPTS stx_o pulses.
5. rst_i asserted while in SETTLE, then released, then start_i -> sweep restarts with code_o=0 and the first write at addr 0.
6. (SWEEP_ABORT_EN) abort_i pulsed in ADC_W at point 1 -> the pending eoadc_i is consumed, no we_o for point 1, no stx_o; eos_o pulses within 2 cycles and busy_o falls.
